fft_frame_seq: RTL and testbench

FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_in_hold.sv | 51 +++++
 rtl/fft_frame_seq.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Holds the FSM state enum, default frame length, forward config word.
package fft_pkg;

  localparam int         FFT_LEN_DEF = 8192;
  localparam logic [7:0] CFG_FWD     = 8'h01;
  localparam int         BEAT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_CFG,
    S_LOAD,
    S_UNLOAD,
    S_DONE
  } state_t;

endpackage

// File: rtl/fft_in_hold.sv
// One-entry sample holding register with valid/ready output and overrun flag.
// Ports: clk, rst_n, clr (frame start), in_valid/in_data, out_valid/out_data/out_ready, overrun.
module fft_in_hold #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         overrun
);

  logic         full;
  logic [W-1:0] data;
  logic         ovr;
  logic         accept;
  logic         drain;

  // a draining register may be refilled in the same cycle
  assign drain  = full & out_ready;
  assign accept = in_valid & (~full | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      ovr  <= 1'b0;
    end else if (clr) begin
      full <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        data <= in_data;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (in_valid & full & ~out_ready)
        ovr <= 1'b1;
    end
  end

  assign out_valid = full;
  assign out_data  = data;
  assign overrun   = ovr;

endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer for an AXI-Stream FFT core: core reset, config, load, unload.
// Ports: fft_clk, rst_n, start, ad_data/ad_valid, fft_aresetn, cfg_t*, s_t*,
// m_tvalid/m_tlast, busy, frame_done, overrun, frame_err.
// Define FFT_DECIM_EN to keep only every DECIM-th ad_valid strobe during LOAD.
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int         FFT_LEN    = FFT_LEN_DEF,
  parameter int         RST_CYCLES = 4,
  parameter logic [7:0] CFG_WORD   = CFG_FWD,
  parameter int         DECIM      = 8
) (
  input  logic        fft_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  ad_data,
  input  logic        ad_valid,
  output logic        fft_aresetn,
  output logic [7:0]  cfg_tdata,
  output logic        cfg_tvalid,
  input  logic        cfg_tready,
  output logic [31:0] s_tdata,
  output logic        s_tvalid,
  input  logic        s_tready,
  output logic        s_tlast,
  input  logic        m_tvalid,
  input  logic        m_tlast,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        frame_err
);

  localparam logic [BEAT_W-1:0] LAST  = BEAT_W'(FFT_LEN - 1);
  localparam logic [15:0]       RLAST = 16'(RST_CYCLES - 1);

  if (FFT_LEN < 64 || FFT_LEN > 65536 ||
      (FFT_LEN & (FFT_LEN - 1)) != 0) begin : g_bad_len
    $error("FFT_LEN must be a power of two in 64..65536");
  end
  if (RST_CYCLES < 2) begin : g_bad_rst
    $error("RST_CYCLES must be at least 2");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("DECIM must be at least 1");
  end

  state_t            state;
  state_t            state_nx;
  logic [BEAT_W-1:0] beat_cnt;
  logic [15:0]       rst_cnt;
  logic              aresetn_q;
  logic              err_q;
  logic              hold_valid;
  logic [9:0]        hold_data;
  logic              clr;
  logic              in_load;
  logic              cand;
  logic              load_en;
  logic              s_xfer;
  logic              last_xfer;
  logic              m_beat;
  logic              m_last_beat;

  assign clr         = (state == S_IDLE) & start;
  assign in_load     = (state == S_LOAD);
  assign s_xfer      = in_load & hold_valid & s_tready;
  assign last_xfer   = s_xfer & (beat_cnt == LAST);
  assign m_beat      = (state == S_UNLOAD) & m_tvalid;
  assign m_last_beat = m_beat & (beat_cnt == LAST);

`ifdef FFT_DECIM_EN
  localparam logic [15:0] DLAST = 16'(DECIM - 1);

  logic [15:0] dec_cnt;

  // held at zero outside LOAD so the DECIM-th strobe is the first sample
  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n)
      dec_cnt <= '0;
    else if (!in_load)
      dec_cnt <= '0;
    else if (ad_valid)
      dec_cnt <= (dec_cnt == DLAST) ? '0 : dec_cnt + 16'd1;
  end

  assign cand = ad_valid & (dec_cnt == DLAST);
`else
  assign cand = ad_valid;
`endif

  // no sample may slip in behind the last beat of the frame
  assign load_en = in_load & cand & ~last_xfer;

  fft_in_hold #(
    .W(10)
  ) u_hold (
    .clk       (fft_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (load_en),
    .in_data   (ad_data),
    .out_valid (hold_valid),
    .out_data  (hold_data),
    .out_ready (s_tready),
    .overrun   (overrun)
  );

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    cfg_tvalid = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = S_CORE_RST;
      end
      S_CORE_RST: begin
        if (rst_cnt == RLAST)
          state_nx = S_CFG;
      end
      S_CFG: begin
        cfg_tvalid = 1'b1;
        if (cfg_tready)
          state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (last_xfer)
          state_nx = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (m_last_beat)
          state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // core reset is registered so it reads low in reset and high one clock after
  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      aresetn_q <= 1'b0;
      rst_cnt   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      aresetn_q <= (state_nx != S_CORE_RST);
      if (state == S_CORE_RST)
        rst_cnt <= rst_cnt + 16'd1;
      else
        rst_cnt <= '0;
      // one counter serves load beats, then unload beats
      if (state == S_IDLE || last_xfer)
        beat_cnt <= '0;
      else if (s_xfer || m_beat)
        beat_cnt <= beat_cnt + 1'b1;
      if (clr)
        err_q <= 1'b0;
      else if (m_beat && (m_tlast != (beat_cnt == LAST)))
        err_q <= 1'b1;
    end
  end

  assign fft_aresetn = aresetn_q;
  assign cfg_tdata   = CFG_WORD;
  assign s_tvalid    = hold_valid;
  assign s_tdata     = {16'h0000, 6'b0, hold_data};
  assign s_tlast     = in_load & hold_valid & (beat_cnt == LAST);
  assign frame_err   = err_q;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed self-checking bench for fft_frame_seq with FFT_LEN=64.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next.
module tb_fft_frame_seq;

  localparam int FLEN = 64;

  logic        fft_clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  ad_data;
  logic        ad_valid;
  logic        fft_aresetn;
  logic [7:0]  cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tlast;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        frame_err;

  fft_frame_seq #(
    .FFT_LEN    (FLEN),
    .RST_CYCLES (4),
    .CFG_WORD   (8'h01),
    .DECIM      (8)
  ) dut (
    .fft_clk     (fft_clk),
    .rst_n       (rst_n),
    .start       (start),
    .ad_data     (ad_data),
    .ad_valid    (ad_valid),
    .fft_aresetn (fft_aresetn),
    .cfg_tdata   (cfg_tdata),
    .cfg_tvalid  (cfg_tvalid),
    .cfg_tready  (cfg_tready),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  initial fft_clk = 1'b0;
  always #5 fft_clk = ~fft_clk;

  int tests = 0;
  int fails = 0;
  int tk = 0;
  int rst_low, cfg_beats, cfg_bad;
  int s_beats, s_last_cnt, s_last_bad;
  int m_beats, done_cnt, done_at;
  int data_bad, gap_bad, first_tk, prev_tk, cfg_tk;
  int tlast_pos = 63;
  logic [9:0]  last_d;
  logic [9:0]  first_d;
  logic [31:0] d0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clr_cnt;
    rst_low = 0; cfg_beats = 0; cfg_bad = 0;
    s_beats = 0; s_last_cnt = 0; s_last_bad = 0;
    m_beats = 0; done_cnt = 0; done_at = -1;
    data_bad = 0; gap_bad = 0; first_tk = -1;
    prev_tk = 0; cfg_tk = -1; last_d = '0; first_d = '0;
  endtask

  // one clock: drive core-output side, sample handshakes, advance
  task automatic tick;
    m_tvalid = (s_beats == FLEN) && (m_beats < FLEN);
    m_tlast  = m_tvalid && (m_beats == tlast_pos);
    ad_data  = tk[9:0];
    #1;
    if (!fft_aresetn) rst_low++;
    if (cfg_tvalid && cfg_tready) begin
      cfg_beats++;
      cfg_tk = tk;
      if (cfg_tdata !== 8'h01) cfg_bad++;
    end
    if (s_tvalid && s_tready) begin
      if (s_tlast !== (s_beats == FLEN - 1)) s_last_bad++;
      if (s_tlast) s_last_cnt++;
      if (s_tdata[31:10] !== 22'd0) data_bad++;
      if (s_beats == 0) begin
        first_tk = tk;
        first_d  = s_tdata[9:0];
      end else begin
        if (s_tdata[9:0] !== last_d + 10'd1) data_bad++;
        if (tk - prev_tk != 8) gap_bad++;
      end
      last_d  = s_tdata[9:0];
      prev_tk = tk;
      s_beats++;
    end
    if (m_tvalid) m_beats++;
    if (frame_done) begin
      done_cnt++;
      done_at = m_beats;
    end
    @(posedge fft_clk);
    #1;
    tk++;
  endtask

  task automatic run_frame(input int maxc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("frame_timeout", done_cnt, 1);
  endtask

  task automatic start_frame;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; start = 1'b0; ad_data = '0; ad_valid = 1'b0;
    cfg_tready = 1'b0; s_tready = 1'b0;
    m_tvalid = 1'b0; m_tlast = 1'b0;
    clr_cnt();
    repeat (2) @(posedge fft_clk);
    #1;
    chk("rst_aresetn", fft_aresetn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_tvalid", cfg_tvalid, 0);
    chk("rst_s_tvalid", s_tvalid, 0);
    chk("rst_s_tlast", s_tlast, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_aresetn_before_edge", fft_aresetn, 0);
    tick();
    chk("rel_aresetn_after_edge", fft_aresetn, 1);

`ifdef FFT_DECIM_EN
    clr_cnt();
    ad_valid = 1'b1; cfg_tready = 1'b1; s_tready = 1'b1;
    start_frame();
    run_frame(1200);
    chk("dec_first_beat_delay", first_tk - cfg_tk, 9);
    chk("dec_first_data", first_d, 10'((cfg_tk + 8) % 1024));
    chk("dec_gap", gap_bad, 0);
    chk("dec_beats", s_beats, FLEN);
    chk("dec_tlast", s_last_cnt, 1);
`else
    // basic frame, everything always ready
    clr_cnt();
    ad_valid = 1'b1; cfg_tready = 1'b1; s_tready = 1'b1;
    start_frame();
    n = 1;
    while (!cfg_tvalid && n < 20) begin
      tick();
      n++;
    end
    chk("cfg_latency", n, 5);
    run_frame(300);
    chk("f1_rst_low", rst_low, 4);
    chk("f1_cfg_beats", cfg_beats, 1);
    chk("f1_cfg_data", cfg_bad, 0);
    chk("f1_s_beats", s_beats, FLEN);
    chk("f1_tlast_cnt", s_last_cnt, 1);
    chk("f1_tlast_pos", s_last_bad, 0);
    chk("f1_data", data_bad, 0);
    chk("f1_m_beats", m_beats, FLEN);
    chk("f1_done_at", done_at, FLEN);
    chk("f1_frame_err", frame_err, 0);
    chk("f1_overrun", overrun, 0);
    chk("f1_busy_end", busy, 0);

    // config back-pressure, then input stall
    clr_cnt();
    cfg_tready = 1'b0;
    start_frame();
    n = 0;
    while (!cfg_tvalid && n < 20) begin
      tick();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!cfg_tvalid || cfg_tdata !== 8'h01) bad++;
      tick();
    end
    chk("f2_cfg_hold", bad, 0);
    chk("f2_cfg_none", cfg_beats, 0);
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    chk("f2_cfg_one", cfg_beats, 1);
    chk("f2_cfg_drop", cfg_tvalid, 0);
    chk("f2_load_empty", s_tvalid, 0);
    tick();
    chk("f2_load_first", s_tvalid, 1);
    n = 0;
    while (s_beats < 10 && n < 100) begin
      tick();
      n++;
    end
    s_tready = 1'b0;
    d0 = s_tdata;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!s_tvalid || s_tdata !== d0) bad++;
    end
    chk("f2_stall_stable", bad, 0);
    chk("f2_overrun_set", overrun, 1);
    s_tready = 1'b1;
    run_frame(300);
    chk("f2_s_beats", s_beats, FLEN);
    chk("f2_tlast_cnt", s_last_cnt, 1);
    chk("f2_tlast_pos", s_last_bad, 0);
    chk("f2_overrun_sticky", overrun, 1);
    chk("f2_frame_err", frame_err, 0);

    // misplaced m_tlast
    clr_cnt();
    cfg_tready = 1'b1;
    tlast_pos = 40;
    start_frame();
    chk("f3_overrun_clr", overrun, 0);
    run_frame(300);
    chk("f3_frame_err", frame_err, 1);
    chk("f3_done_at", done_at, FLEN);
    chk("f3_m_beats", m_beats, FLEN);
    clr_cnt();
    tlast_pos = 63;
    start_frame();
    chk("f4_err_clr", frame_err, 0);
    run_frame(300);
    chk("f4_frame_err", frame_err, 0);

    // start while busy, then reset mid-frame
    clr_cnt();
    start_frame();
    n = 0;
    while (s_beats < 5 && n < 100) begin
      tick();
      n++;
    end
    start_frame();
    chk("f5_busy", busy, 1);
    n = 0;
    while (s_beats < 20 && n < 100) begin
      tick();
      n++;
    end
    chk("f5_beats", s_beats, 20);
    chk("f5_no_restart", rst_low, 4);
    rst_n = 1'b0;
    #1;
    chk("f5_rst_busy", busy, 0);
    chk("f5_rst_aresetn", fft_aresetn, 0);
    chk("f5_rst_s_tvalid", s_tvalid, 0);
    @(posedge fft_clk);
    #1;
    rst_n = 1'b1;
    repeat (20) tick();
    chk("f5_no_done", done_cnt, 0);
    chk("f5_idle", busy, 0);
    chk("f5_aresetn", fft_aresetn, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
